register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file: configurable data width and depth, explicit write enable, optional hardwired zero register, and read-enable/valid qualifiers.
- Adds a sequential bulk-clear engine that zeroes the array one entry per cycle.
- Sits in the decode stage. The rs/rt operands feed execute one cycle after the address is presented, and writeback drives the write port.

Parameters:
- DATA_WIDTH, 32, register width in bits; bit 0 is the MSB.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG, 1, when 1 entry 0 always reads zero and writes to it are dropped; when 0 entry 0 is an ordinary register.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- rsAddr  input  ADDR_WIDTH  read port A address.
- rtAddr  input  ADDR_WIDTH  read port B address.
- readEnable  input  1  samples both read ports this edge.
- rsOut  output  DATA_WIDTH  registered read data, port A.
- rtOut  output  DATA_WIDTH  registered read data, port B.
- readValid  output  1  rsOut/rtOut were updated on the last edge.
- rdAddr  input  ADDR_WIDTH  write address.
- writeEnable  input  1  write request.
- writeData  input  DATA_WIDTH  write data.
- clearReq  input  1  start bulk clear (level sampled in IDLE).
- busy  output  1  clear engine active.
- clearDone  output  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (resetN low, asynchronous): all DEPTH entries = 0, rsOut = rtOut = 0, readValid = 0, busy = 0, clearDone = 0, FSM = IDLE, clear counter = 0. Holds while resetN is low. Normal operation resumes on the first rising edge after release.
- Reads:
  - On an edge with readEnable = 1: rsOut <= entry[rsAddr], rtOut <= entry[rtAddr]. Latency is 1 cycle.
  - readValid <= readEnable every edge.
  - With readEnable = 0, rsOut/rtOut hold their previous values.
- Zero register: with ZERO_REG = 1, reading address 0 yields 0 on either port.
- Writes:
  - Accepted on an edge when writeEnable = 1, FSM = IDLE, and not (ZERO_REG = 1 and rdAddr = 0).
  - An accepted write sets entry[rdAddr] <= writeData.
  - Writes in CLEAR state are silently dropped; the producer must observe busy.
- Same-edge read of the address being written: returns the OLD value unless REGFILE_BYPASS_EN is defined.
- Both read ports may address the same entry; both return the same data.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clearReq = 1. Counter <= 0, busy <= 1.
  - A write accepted on that same edge still takes effect; it is later overwritten by the clear.
  - CLEAR, each edge: entry[counter] <= 0, counter <= counter + 1.
  - When counter = DEPTH-1 that entry is cleared, FSM -> IDLE, busy <= 0, clearDone <= 1 for exactly one cycle.
  - busy is high for exactly DEPTH cycles.
  - clearReq is ignored while in CLEAR. If clearReq is still high on the edge after returning to IDLE, a new clear starts.
- Reads during CLEAR are permitted and return current contents: cleared entries read 0, not-yet-cleared entries read old data.
- Reset asserted mid-clear: array zeroed immediately, FSM = IDLE, busy = 0, no clearDone pulse.
- Counter is ADDR_WIDTH bits and wraps naturally; there is no terminal overflow.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If a read port's address equals the address being written on the same edge (accepted write, or the clear engine's current entry), that port captures the new value (writeData, or 0 for a clear) instead of the stale array value.
  - The zero-register rule still overrides: address 0 reads 0 when ZERO_REG = 1.
- Not defined: no forwarding. Same-edge reads return the pre-write value. Consumers add one cycle of spacing or external forwarding.

Test Plan:
- Reset then read: assert resetN = 0 mid-cycle; rsOut/rtOut go 0 without waiting for a clock edge. After release, read addresses 0..31 -> all 0, readValid follows readEnable delayed by 1.
- Write/read: write 0xDEADBEEF to r5, then read rs = 5, rt = 5 next cycle -> both 0xDEADBEEF one cycle later. Write r0 = 0x12345678 with ZERO_REG = 1 -> r0 reads 0.
- Same-edge hazard: write r7 = 0xA5A5A5A5 while reading rs = 7 (old value 0x1).
  - Without REGFILE_BYPASS_EN: rsOut = 0x1.
  - With it: rsOut = 0xA5A5A5A5.
- Bulk clear: fill r1..r31 with nonzero values, pulse clearReq -> busy high 32 cycles, clearDone single pulse on the final cycle, all entries read 0 afterward. A writeEnable to r3 during busy is dropped (r3 = 0 after clear).
- Reset mid-clear: start clear, assert resetN after 10 cycles -> busy = 0 immediately, no clearDone, all entries 0, FSM accepts a new clearReq after release.

Source files
------------

// File: rtl/register_file_mp.sv
// ---------------------------------------------------------------------------
// register_file_mp
//
// Parametrised 2-read / 1-write register file for the decode stage, with a
// sequential bulk-clear engine that zeroes one entry per cycle.
//
// Parameters:
//   DATA_WIDTH  register width in bits (bit 0 is the MSB)
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH entries
//   ZERO_REG    1: entry 0 always reads zero and writes to it are dropped
//
// Ports:
//   clock        rising-edge clock
//   resetN       asynchronous active-low reset
//   rsAddr       read port A address
//   rtAddr       read port B address
//   readEnable   capture both read ports on this edge
//   rsOut/rtOut  registered read data (1-cycle latency, hold when not enabled)
//   readValid    rsOut/rtOut were updated on the last edge
//   rdAddr       write address
//   writeEnable  write request (dropped while the clear engine is busy)
//   writeData    write data
//   clearReq     start a bulk clear (level sampled in IDLE)
//   busy         clear engine active (high for exactly DEPTH cycles)
//   clearDone    one-cycle pulse after the final entry is cleared
//
// Handshake: a read is a single-cycle request; readValid is high in the cycle
// following every edge that sampled readEnable = 1, and rsOut/rtOut are valid
// for exactly that request. There is no back-pressure on reads. Writes have no
// acknowledge: the producer must watch busy, writes during a clear are lost.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined     - a read of the entry being written on the same edge (accepted
//                 write or the clear engine's current entry) returns the new
//                 value.
//   Not defined - same-edge reads return the pre-write value.
// ---------------------------------------------------------------------------
module register_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic [ADDR_WIDTH-1:0]   rsAddr,
    input  logic [ADDR_WIDTH-1:0]   rtAddr,
    input  logic                    readEnable,
    output logic [0:DATA_WIDTH-1]   rsOut,
    output logic [0:DATA_WIDTH-1]   rtOut,
    output logic                    readValid,
    input  logic [ADDR_WIDTH-1:0]   rdAddr,
    input  logic                    writeEnable,
    input  logic [0:DATA_WIDTH-1]   writeData,
    input  logic                    clearReq,
    output logic                    busy,
    output logic                    clearDone
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_clr_cnt;
    logic                    r_clear_done;
    logic [0:DATA_WIDTH-1]   r_mem [DEPTH];

    logic                    w_wr_accept;
    logic                    w_clr_last;
    logic [0:DATA_WIDTH-1]   w_rs_data;
    logic [0:DATA_WIDTH-1]   w_rt_data;

    // Writes only land in IDLE; the hardwired zero entry swallows its writes.
    assign w_wr_accept = writeEnable && (r_state == ST_IDLE) &&
                         !((ZERO_REG != 0) && (rdAddr == '0));

    assign w_clr_last  = (r_state == ST_CLEAR) &&
                         (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (clearReq)   w_state_next = ST_CLEAR;
            ST_CLEAR: if (w_clr_last) w_state_next = ST_IDLE;
            default:                  w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // busy is a decode of the registered state, so it rises on the edge that
    // leaves IDLE and falls on the edge that clears the last entry.
    always_comb begin
        busy      = (r_state == ST_CLEAR);
        clearDone = r_clear_done;
    end

    // ---------------- Read data selection ----------------
    // The zero-register rule is applied last so it overrides any forwarding.
    always_comb begin
        w_rs_data = r_mem[rsAddr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_accept && (rdAddr == rsAddr)) begin
            w_rs_data = writeData;
        end else if ((r_state == ST_CLEAR) && (r_clr_cnt == rsAddr)) begin
            w_rs_data = '0;
        end
`endif
        if ((ZERO_REG != 0) && (rsAddr == '0)) begin
            w_rs_data = '0;
        end
    end

    always_comb begin
        w_rt_data = r_mem[rtAddr];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_accept && (rdAddr == rtAddr)) begin
            w_rt_data = writeData;
        end else if ((r_state == ST_CLEAR) && (r_clr_cnt == rtAddr)) begin
            w_rt_data = '0;
        end
`endif
        if ((ZERO_REG != 0) && (rtAddr == '0)) begin
            w_rt_data = '0;
        end
    end

    // ---------------- Array, read registers, clear engine ----------------
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            rsOut        <= '0;
            rtOut        <= '0;
            readValid    <= 1'b0;
            r_clr_cnt    <= '0;
            r_clear_done <= 1'b0;
        end else begin
            readValid <= readEnable;
            if (readEnable) begin
                rsOut <= w_rs_data;
                rtOut <= w_rt_data;
            end

            if (w_wr_accept) begin
                r_mem[rdAddr] <= writeData;
            end

            // The counter wraps back to 0 after the last entry, so it is
            // already at 0 when the next clear starts; the explicit load on
            // entry keeps that independent of history.
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
                r_clr_cnt        <= r_clr_cnt + 1'b1;
            end else if (clearReq) begin
                r_clr_cnt <= '0;
            end

            r_clear_done <= w_clr_last;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// ---------------------------------------------------------------------------
// tb_register_file_mp
//
// Directed bench for register_file_mp (default parameters: 32 x 32, ZERO_REG=1).
// Read requests push their expected data into queues; a monitor on the falling
// edge pops and compares whenever readValid is high, and also tracks busy and
// clearDone activity.
// ---------------------------------------------------------------------------
module tb_register_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] rsAddr;
  logic [AW-1:0] rtAddr;
  logic          readEnable;
  logic [0:DW-1] rsOut;
  logic [0:DW-1] rtOut;
  logic          readValid;
  logic [AW-1:0] rdAddr;
  logic          writeEnable;
  logic [0:DW-1] writeData;
  logic          clearReq;
  logic          busy;
  logic          clearDone;

  register_file_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ZERO_REG   (1)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .rsAddr      (rsAddr),
    .rtAddr      (rtAddr),
    .readEnable  (readEnable),
    .rsOut       (rsOut),
    .rtOut       (rtOut),
    .readValid   (readValid),
    .rdAddr      (rdAddr),
    .writeEnable (writeEnable),
    .writeData   (writeData),
    .clearReq    (clearReq),
    .busy        (busy),
    .clearDone   (clearDone)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int errors   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [DW-1:0] exp_rs_q[$];
  logic [DW-1:0] exp_rt_q[$];
  logic          exp_valid;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // readValid must echo the readEnable seen on the previous edge.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) exp_valid <= 1'b0;
    else         exp_valid <= readEnable;
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (resetN) begin
      check("readValid", {31'd0, readValid}, {31'd0, exp_valid});
      if (readValid) begin
        if (exp_rs_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got readValid=1 expected no pending read at %0t", $time);
        end else begin
          check("rsOut", rsOut, exp_rs_q.pop_front());
          check("rtOut", rtOut, exp_rt_q.pop_front());
        end
      end
      if (busy) busy_cnt++;
      if (clearDone) begin
        done_cnt++;
        check("busy_low_with_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [DW-1:0] ers, input logic [DW-1:0] ert, input logic clr);
    writeEnable = we;
    rdAddr      = rd;
    writeData   = wd;
    readEnable  = re;
    rsAddr      = rs;
    rtAddr      = rt;
    clearReq    = clr;
    if (re) begin
      exp_rs_q.push_back(ers);
      exp_rt_q.push_back(ert);
    end
    @(posedge clock);
    #1;
    writeEnable = 1'b0;
    readEnable  = 1'b0;
    clearReq    = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] rd, input logic [DW-1:0] wd);
    cycle(1'b1, rd, wd, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd2(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input logic [DW-1:0] ers, input logic [DW-1:0] ert);
    cycle(1'b0, '0, '0, 1'b1, rs, rt, ers, ert, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic start_clear();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] fill_val(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed test sequence ----------------
  logic [DW-1:0] hz_exp;

  initial begin
    rsAddr = '0; rtAddr = '0; readEnable = 1'b0;
    rdAddr = '0; writeEnable = 1'b0; writeData = '0; clearReq = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_rsOut", rsOut, 32'd0);
    check("reset_rtOut", rtOut, 32'd0);
    check("reset_readValid", {31'd0, readValid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_clearDone", {31'd0, clearDone}, 32'd0);
    resetN = 1'b1;

    // All entries read zero after reset, both ports, back-to-back
    for (int i = 0; i < DEPTH; i++) rd2(AW'(i), AW'(DEPTH - 1 - i), 32'd0, 32'd0);
    idle(1);

    // Basic write/read and hardwired zero register
    wr(5'd5, 32'hDEAD_BEEF);
    rd2(5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wr(5'd0, 32'h1234_5678);
    rd2(5'd0, 5'd5, 32'd0, 32'hDEAD_BEEF);
    idle(1);

    // Asynchronous reset mid-cycle: outputs drop without a clock edge
    #2;
    resetN = 1'b0;
    #1;
    check("async_rst_rsOut", rsOut, 32'd0);
    check("async_rst_rtOut", rtOut, 32'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    rd2(5'd5, 5'd5, 32'd0, 32'd0);

    // Same-edge write/read hazard on r7
    wr(5'd7, 32'h0000_0001);
`ifdef REGFILE_BYPASS_EN
    hz_exp = 32'hA5A5_A5A5;
`else
    hz_exp = 32'h0000_0001;
`endif
    cycle(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 5'd7, hz_exp, hz_exp, 1'b0);
    rd2(5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // Fill r1..r31 and spot-check
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), fill_val(i));
    rd2(5'd3, 5'd31, fill_val(3), fill_val(31));
    rd2(5'd0, 5'd16, 32'd0, fill_val(16));
    idle(1);

    // Bulk clear: edge E0 starts it, entry k is cleared on edge E(k+1)
    busy_cnt = 0;
    done_cnt = 0;
    start_clear();                                              // E0
    check("clear_busy_start", {31'd0, busy}, 32'd1);
    wr(5'd3, 32'h3333_3333);                                    // E1, dropped
    rd2(5'd3, 5'd30, fill_val(3), fill_val(30));                // E2
    idle(2);                                                    // E3, E4
    rd2(5'd30, 5'd1, fill_val(30), 32'd0);                      // E5
    wait_done(100);
    idle(2);
    check("clear_done_count", done_cnt, 32'd1);
    check("clear_busy_cycles", busy_cnt, 32'd32);
    for (int i = 0; i < DEPTH; i++) rd2(AW'(i), AW'(i), 32'd0, 32'd0);
    idle(1);

    // Reset in the middle of a clear
    wr(5'd9, 32'h0000_0099);
    wr(5'd31, 32'h3131_3131);
    busy_cnt = 0;
    done_cnt = 0;
    start_clear();
    idle(10);
    #2;
    resetN = 1'b0;
    #1;
    check("midclr_rst_busy", {31'd0, busy}, 32'd0);
    check("midclr_rst_clearDone", {31'd0, clearDone}, 32'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    idle(2);
    check("midclr_no_done", done_cnt, 32'd0);
    rd2(5'd9, 5'd31, 32'd0, 32'd0);

    // A new clear is accepted after the aborted one
    busy_cnt = 0;
    done_cnt = 0;
    start_clear();
    check("reclear_busy_start", {31'd0, busy}, 32'd1);
    wait_done(100);
    idle(2);
    check("reclear_done_count", done_cnt, 32'd1);
    check("reclear_busy_cycles", busy_cnt, 32'd32);

    idle(2);
    check("pending_reads", exp_rs_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
